// File: rtl/min_search_ctrl.sv
// Streams Count unsigned words through one shared lt/eq/gt comparator and reports min value/index (plus max when MAX_TRACK_EN is defined).
// Done pulses the cycle after the last element is accepted; InValid=0 stalls the scan, and InReady is high only in SCAN.

module min_search_cmp #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_lt,
    output logic         o_eq,
    output logic         o_gt
);
    assign o_lt = (i_a <  i_b);
    assign o_eq = (i_a == i_b);
    assign o_gt = (i_a >  i_b);
endmodule

module min_search_ctrl #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [IDX_W-1:0]  i_count,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_min_val,
    output logic [IDX_W-1:0]  o_min_idx
`ifdef MAX_TRACK_EN
    ,
    output logic [DATA_W-1:0] o_max_val,
    output logic [IDX_W-1:0]  o_max_idx
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_count;
    logic [DATA_W-1:0]  r_min_val;
    logic [IDX_W-1:0]   r_min_idx;

    logic w_lt;
    logic w_eq;
    logic w_gt;
    logic w_accept;
    logic w_last;
    logic w_first;
    logic w_upd_min;

    min_search_cmp #(.W(DATA_W)) u_cmp (
        .i_a  (i_in_data),
        .i_b  (r_min_val),
        .o_lt (w_lt),
        .o_eq (w_eq),
        .o_gt (w_gt)
    );

    assign w_accept  = (r_state == S_SCAN) && i_in_valid;
    assign w_last    = (r_idx == (r_count - IDX_W'(1)));
    assign w_first   = (r_idx == '0);
    // Strict less-than: a tie (eq) never displaces the earlier index.
    assign w_upd_min = w_first || (w_lt && !(w_eq || w_gt));

`ifdef MAX_TRACK_EN
    logic [DATA_W-1:0] r_max_val;
    logic [IDX_W-1:0]  r_max_idx;
    logic              w_mx_lt;
    logic              w_mx_eq;
    logic              w_mx_gt;
    logic              w_upd_max;

    // Same comparator structure against the running maximum.
    min_search_cmp #(.W(DATA_W)) u_cmp_max (
        .i_a  (i_in_data),
        .i_b  (r_max_val),
        .o_lt (w_mx_lt),
        .o_eq (w_mx_eq),
        .o_gt (w_mx_gt)
    );

    assign w_upd_max = w_first || (w_mx_gt && !(w_mx_eq || w_mx_lt));
    assign o_max_val = r_max_val;
    assign o_max_idx = r_max_idx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_max_val <= '0;
            r_max_idx <= '0;
        end else if (r_state == S_IDLE && i_start && i_count == '0) begin
            r_max_val <= '0;
            r_max_idx <= '0;
        end else if (w_accept && w_upd_max) begin
            r_max_val <= i_in_data;
            r_max_idx <= r_idx;
        end
    end
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = (i_count == '0) ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_accept && w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_count   <= '0;
            r_min_val <= '0;
            r_min_idx <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_count <= i_count;
                        r_idx   <= '0;
                        if (i_count == '0) begin
                            r_min_val <= '1;
                            r_min_idx <= '0;
                        end
                    end
                end
                S_SCAN: begin
                    if (w_accept) begin
                        // Index wraps to 0 on the last element so it never exceeds Count-1.
                        r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
                        if (w_upd_min) begin
                            r_min_val <= i_in_data;
                            r_min_idx <= r_idx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_in_ready = (r_state == S_SCAN);
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_min_val  = r_min_val;
    assign o_min_idx  = r_min_idx;

endmodule

// File: tb/tb_min_search_ctrl.sv
// Directed bench for min_search_ctrl; Max checks are compiled in when MAX_TRACK_EN is defined.
module tb_min_search_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  count;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic [31:0] min_val;
    logic [7:0]  min_idx;
`ifdef MAX_TRACK_EN
    logic [31:0] max_val;
    logic [7:0]  max_idx;
`endif

    int tests_run;
    int tests_failed;

    min_search_ctrl #(.DATA_W(32), .IDX_W(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_count    (count),
        .i_in_valid (in_valid),
        .i_in_data  (in_data),
        .o_in_ready (in_ready),
        .o_busy     (busy),
        .o_done     (done),
        .o_min_val  (min_val),
        .o_min_idx  (min_idx)
`ifdef MAX_TRACK_EN
        ,
        .o_max_val  (max_val),
        .o_max_idx  (max_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Presents one word, waits (bounded) for InReady, lets one edge accept it.
    task automatic send(input logic [31:0] d);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!in_ready) chk("send_ready_timeout", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b0;
        start    = 1'b0;
        count    = 8'd0;
        in_valid = 1'b0;
        in_data  = 32'd0;

        // Asynchronous reset pulse between clock edges.
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_done",     {31'd0, done},     32'd0);
        chk("rst_min_val",  min_val,           32'd0);
        chk("rst_min_idx",  {24'd0, min_idx},  32'd0);
`ifdef MAX_TRACK_EN
        chk("rst_max_val",  max_val,           32'd0);
        chk("rst_max_idx",  {24'd0, max_idx},  32'd0);
`endif
        #1 rst = 1'b0;
        step();

        // Test 1: Count=4, back-to-back 9,3,7,5.
        start = 1'b1;
        count = 8'd4;
        step();
        start = 1'b0;
        chk("t1_busy_scan",  {31'd0, busy},     32'd1);
        chk("t1_ready_scan", {31'd0, in_ready}, 32'd1);
        send(32'd9);
        send(32'd3);
        send(32'd7);
        chk("t1_no_early_done", {31'd0, done}, 32'd0);
        send(32'd5);
        chk("t1_done",      {31'd0, done},     32'd1);
        chk("t1_ready_off", {31'd0, in_ready}, 32'd0);
        chk("t1_busy_done", {31'd0, busy},     32'd1);
        chk("t1_min_val",   min_val,           32'd3);
        chk("t1_min_idx",   {24'd0, min_idx},  32'd1);
        step();
        chk("t1_done_drop", {31'd0, done}, 32'd0);
        chk("t1_busy_drop", {31'd0, busy}, 32'd0);
        idle(2);
        chk("t1_hold_val", min_val, 32'd3);

        // Test 2: Count=5, 6,2,8,2,4 with 2-cycle gaps.
        start = 1'b1;
        count = 8'd5;
        step();
        start = 1'b0;
        chk("t2_not_cleared", min_val, 32'd3);
        send(32'd6);
        idle(2);
        chk("t2_ready_gap", {31'd0, in_ready}, 32'd1);
        send(32'd2);
        idle(2);
        send(32'd8);
        idle(2);
        send(32'd2);
        idle(2);
        chk("t2_no_done_gap", {31'd0, done},     32'd0);
        chk("t2_ready_gap2",  {31'd0, in_ready}, 32'd1);
        send(32'd4);
        chk("t2_done",    {31'd0, done},    32'd1);
        chk("t2_min_val", min_val,          32'd2);
        chk("t2_min_idx", {24'd0, min_idx}, 32'd1);
        step();
        chk("t2_single_pulse", {31'd0, done}, 32'd0);

        // Test 3: Count=0.
        start = 1'b1;
        count = 8'd0;
        chk("t3_ready_idle", {31'd0, in_ready}, 32'd0);
        step();
        start = 1'b0;
        chk("t3_done",     {31'd0, done},     32'd1);
        chk("t3_ready",    {31'd0, in_ready}, 32'd0);
        chk("t3_min_val",  min_val,           32'hFFFF_FFFF);
        chk("t3_min_idx",  {24'd0, min_idx},  32'd0);
`ifdef MAX_TRACK_EN
        chk("t3_max_val",  max_val,           32'd0);
        chk("t3_max_idx",  {24'd0, max_idx},  32'd0);
`endif
        step();
        chk("t3_done_drop", {31'd0, done}, 32'd0);
        chk("t3_busy_drop", {31'd0, busy}, 32'd0);

        // Test 4: unsigned compare; Start/Count during scan ignored.
        start = 1'b1;
        count = 8'd3;
        step();
        start = 1'b0;
        send(32'hFFFF_FFFF);
        start = 1'b1;
        count = 8'd1;
        send(32'h8000_0000);
        start = 1'b0;
        chk("t4_ignore_start", {31'd0, done}, 32'd0);
        chk("t4_still_busy",   {31'd0, busy}, 32'd1);
        send(32'h0000_0001);
        chk("t4_done",    {31'd0, done},    32'd1);
        chk("t4_min_val", min_val,          32'd1);
        chk("t4_min_idx", {24'd0, min_idx}, 32'd2);
        step();

        // Test 5: reset mid-scan, then fresh scan.
        start = 1'b1;
        count = 8'd6;
        step();
        start = 1'b0;
        send(32'd1);
        send(32'd2);
        send(32'd3);
        #3 rst = 1'b1;
        #1;
        chk("t5_rst_done",    {31'd0, done},     32'd0);
        chk("t5_rst_busy",    {31'd0, busy},     32'd0);
        chk("t5_rst_ready",   {31'd0, in_ready}, 32'd0);
        chk("t5_rst_min_val", min_val,           32'd0);
        chk("t5_rst_min_idx", {24'd0, min_idx},  32'd0);
        rst = 1'b0;
        step();
        chk("t5_no_done", {31'd0, done}, 32'd0);
        start = 1'b1;
        count = 8'd2;
        step();
        start = 1'b0;
        send(32'd10);
        send(32'd4);
        chk("t5_done",    {31'd0, done},    32'd1);
        chk("t5_min_val", min_val,          32'd4);
        chk("t5_min_idx", {24'd0, min_idx}, 32'd1);
        step();

        // Test 6: 5,9,1,9 (max tie keeps first 9).
        start = 1'b1;
        count = 8'd4;
        step();
        start = 1'b0;
        send(32'd5);
        send(32'd9);
        send(32'd1);
        send(32'd9);
        chk("t6_done",    {31'd0, done},    32'd1);
        chk("t6_min_val", min_val,          32'd1);
        chk("t6_min_idx", {24'd0, min_idx}, 32'd2);
`ifdef MAX_TRACK_EN
        chk("t6_max_val", max_val,          32'd9);
        chk("t6_max_idx", {24'd0, max_idx}, 32'd1);
`endif
        step();
        chk("t6_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
